// File: rtl/wb_counter_pkg.sv
// Shared definitions for the Wishbone counter bank.
// Holds the per-channel register word offsets, the CTRL/STATUS bit positions,
// the address window geometry and a byte-enable merge helper.
package wb_counter_pkg;

  // Caravel user-area GPIO count.
  localparam int unsigned MPRJ_IO_PADS = 38;

  // Address geometry: each channel owns a 16-byte slot inside a 256-byte window.
  localparam int unsigned ChStride = 32'h10;
  localparam int unsigned WinSize  = 32'h100;

  // Register word index within a channel slot (byte offset / 4).
  typedef enum logic [1:0] {
    RegCtrl   = 2'd0,  // +0x0
    RegLoad   = 2'd1,  // +0x4
    RegCount  = 2'd2,  // +0x8
    RegStatus = 2'd3   // +0xC
  } reg_sel_e;

  // CTRL bits.
  localparam int unsigned CtrlEn     = 0;
  localparam int unsigned CtrlDir    = 1;  // 0 = up, 1 = down
  localparam int unsigned CtrlReload = 2;  // 1 = auto-reload, 0 = one-shot
  localparam int unsigned CtrlIrqEn  = 3;
  localparam int unsigned CtrlW      = 4;

  // STATUS bits.
  localparam int unsigned StatTc  = 0;
  localparam int unsigned StatOvr = 1;
  localparam int unsigned StatW   = 2;

  // Replace the bytes of old_val selected by sel with the matching bytes of wdata.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: CTRL/LOAD/COUNT/STATUS registers, up/down stepping,
// terminal detection with one-shot or auto-reload, and a registered
// one-cycle terminal pulse.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   wr_en_i           bus write strobe for this channel
//   wr_reg_i          register word being written (reg_sel_e encoding)
//   wr_data_i/sel_i   write data and byte enables
//   ctrl_o .. status_o current register values for the read mux / irq logic
//   tc_pulse_o        high for one cycle, the cycle after a terminal event
module counter_channel
  import wb_counter_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_reg_i,
  input  logic [31:0]       wr_data_i,
  input  logic [3:0]        wr_sel_i,
  output logic [CtrlW-1:0]  ctrl_o,
  output logic [CNT_W-1:0]  load_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [StatW-1:0]  status_o,
  output logic              tc_pulse_o
);

  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [StatW-1:0] status_q, status_d;
  logic             tc_pulse_q;

  logic wr_ctrl, wr_load, wr_count, wr_status;
  logic step, terminal;
  logic [31:0] ctrl_m, load_m, count_m;
  logic [StatW-1:0] w1c;

  assign wr_ctrl   = wr_en_i && (wr_reg_i == RegCtrl);
  assign wr_load   = wr_en_i && (wr_reg_i == RegLoad);
  assign wr_count  = wr_en_i && (wr_reg_i == RegCount);
  assign wr_status = wr_en_i && (wr_reg_i == RegStatus);

  assign ctrl_m  = apply_sel(32'(ctrl_q), wr_data_i, wr_sel_i);
  assign load_m  = apply_sel(32'(load_q), wr_data_i, wr_sel_i);
  assign count_m = apply_sel(32'(count_q), wr_data_i, wr_sel_i);
  assign w1c     = wr_sel_i[0] ? wr_data_i[StatW-1:0] : '0;

  // A bus write to COUNT pre-empts the step and terminal evaluation that cycle.
  assign step     = ctrl_q[CtrlEn] && !wr_count;
  assign terminal = step && (ctrl_q[CtrlDir] ? (count_q == '0) : (count_q == load_q));

  always_comb begin
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    count_d  = count_q;
    status_d = status_q;

    if (terminal) begin
      if (ctrl_q[CtrlReload]) begin
        count_d = ctrl_q[CtrlDir] ? load_q : '0;
      end else begin
        ctrl_d[CtrlEn] = 1'b0;
      end
    end else if (step) begin
      count_d = ctrl_q[CtrlDir] ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
    end

    // A CTRL write overrides the one-shot EN clear, but the terminal is still flagged below.
    if (wr_ctrl)   ctrl_d   = ctrl_m[CtrlW-1:0];
    if (wr_load)   load_d   = load_m[CNT_W-1:0];
    if (wr_count)  count_d  = count_m[CNT_W-1:0];
    if (wr_status) status_d = status_q & ~w1c;

    // Setting after the clear makes a coincident terminal win over W1C.
    if (terminal) begin
      status_d[StatTc] = 1'b1;
      if (status_q[StatTc]) status_d[StatOvr] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      load_q     <= '0;
      count_q    <= '0;
      status_q   <= '0;
      tc_pulse_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      count_q    <= count_d;
      status_q   <= status_d;
      tc_pulse_q <= terminal;
    end
  end

  assign ctrl_o     = ctrl_q;
  assign load_o     = load_q;
  assign count_o    = count_q;
  assign status_o   = status_q;
  assign tc_pulse_o = tc_pulse_q;

  logic unused_wr;
  assign unused_wr = ^{ctrl_m, load_m, count_m};

endmodule

// File: rtl/wb_counter_bank.sv
// Multi-channel Wishbone counter bank for the Caravel user area.
// NUM_CH channels of CNT_W-bit up/down counters with one-shot or auto-reload,
// terminal-count and overrun flags, GPIO terminal pulses and aggregated irqs.
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wbs_*                  Wishbone classic slave (256-byte window at BASE_ADR)
//   la_data_in/la_oenb     unused
//   la_data_out            channel 0 count in the low CNT_W bits
//   io_in                  unused
//   io_out/io_oeb          channel terminal pulses on IO_BASE.. (driven outputs)
//   irq                    [0] any enabled TC, [1] any enabled OVR, [2] zero
module wb_counter_bank
  import wb_counter_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned IO_BASE  = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [127:0]            la_data_in,
  input  logic [127:0]            la_oenb,
  output logic [127:0]            la_data_out,
  input  logic [MPRJ_IO_PADS-1:0] io_in,
  output logic [MPRJ_IO_PADS-1:0] io_out,
  output logic [MPRJ_IO_PADS-1:0] io_oeb,
  output logic [2:0]              irq
);

  localparam int unsigned StrideBits = $clog2(ChStride);
  localparam int unsigned WinBits    = $clog2(WinSize);
  localparam int unsigned IdxW       = WinBits - StrideBits;

  logic                        ack_q;
  logic [31:0]                 dat_q;
  logic [1:0]                  irq_q;
  logic                        in_win, req;
  logic [IdxW-1:0]             ch_idx;
  logic [1:0]                  reg_word;
  logic [31:0]                 rdata;
  logic                        tc_any, ovr_any;

  logic [NUM_CH-1:0]             wr_en;
  logic [NUM_CH-1:0][CtrlW-1:0]  ctrl;
  logic [NUM_CH-1:0][CNT_W-1:0]  load;
  logic [NUM_CH-1:0][CNT_W-1:0]  count;
  logic [NUM_CH-1:0][StatW-1:0]  status;
  logic [NUM_CH-1:0]             tc_pulse;

  assign in_win   = (wbs_adr_i[31:WinBits] == BASE_ADR[31:WinBits]);
  assign ch_idx   = wbs_adr_i[WinBits-1:StrideBits];
  assign reg_word = wbs_adr_i[StrideBits-1:2];
  // Blocking on ack_q forces a one-cycle gap between back-to-back requests.
  assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q & in_win;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Channels at or beyond NUM_CH never match, so their writes are dropped.
    assign wr_en[c] = req & wbs_we_i & (32'(ch_idx) == 32'(c));

    counter_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk_i      (wb_clk_i),
      .rst_i      (wb_rst_i),
      .wr_en_i    (wr_en[c]),
      .wr_reg_i   (reg_word),
      .wr_data_i  (wbs_dat_i),
      .wr_sel_i   (wbs_sel_i),
      .ctrl_o     (ctrl[c]),
      .load_o     (load[c]),
      .count_o    (count[c]),
      .status_o   (status[c]),
      .tc_pulse_o (tc_pulse[c])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(ch_idx) == 32'(i)) begin
        unique case (reg_word)
          RegCtrl:   rdata = 32'(ctrl[i]);
          RegLoad:   rdata = 32'(load[i]);
          RegCount:  rdata = 32'(count[i]);
          RegStatus: rdata = 32'(status[i]);
          default:   rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    tc_any  = 1'b0;
    ovr_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      tc_any  = tc_any | (status[i][StatTc] & ctrl[i][CtrlIrqEn]);
      ovr_any = ovr_any | (status[i][StatOvr] & ctrl[i][CtrlIrqEn]);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= '0;
    end else begin
      ack_q <= req;
      if (req) dat_q <= rdata;
      irq_q <= {ovr_any, tc_any};
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = {1'b0, irq_q};

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      io_out[IO_BASE + i] = tc_pulse[i];
      io_oeb[IO_BASE + i] = 1'b0;
    end
  end

  always_comb begin
    la_data_out            = '0;
    la_data_out[CNT_W-1:0] = count[0];
  end

  logic unused_in;
  assign unused_in = ^{la_data_in, la_oenb, io_in, wbs_adr_i[1:0]};

endmodule

// File: tb/tb_wb_counter_bank.sv
// Directed bench for wb_counter_bank: a default instance (4 x 32-bit) and a
// NUM_CH=1, CNT_W=8 instance at a second base address share the bus inputs.
module tb_wb_counter_bank;
  import wb_counter_pkg::*;

  localparam logic [31:0] Base  = 32'h3000_0000;
  localparam logic [31:0] Base8 = 32'h3000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat_w = '0;

  logic        ack, ack8;
  logic [31:0] dat, dat8;
  logic [127:0] la_out, la_out8;
  logic [MPRJ_IO_PADS-1:0] io_out, io_oeb, io_out8, io_oeb8;
  logic [2:0] irq, irq8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_counter_bank #(
    .NUM_CH (4), .CNT_W (32), .BASE_ADR (Base), .IO_BASE (8)
  ) dut (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbs_cyc_i (cyc), .wbs_stb_i (stb), .wbs_we_i (we), .wbs_sel_i (sel),
    .wbs_adr_i (adr), .wbs_dat_i (dat_w), .wbs_ack_o (ack), .wbs_dat_o (dat),
    .la_data_in ('0), .la_oenb ('0), .la_data_out (la_out),
    .io_in ('0), .io_out (io_out), .io_oeb (io_oeb), .irq (irq)
  );

  wb_counter_bank #(
    .NUM_CH (1), .CNT_W (8), .BASE_ADR (Base8), .IO_BASE (8)
  ) dut8 (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbs_cyc_i (cyc), .wbs_stb_i (stb), .wbs_we_i (we), .wbs_sel_i (sel),
    .wbs_adr_i (adr), .wbs_dat_i (dat_w), .wbs_ack_o (ack8), .wbs_dat_o (dat8),
    .la_data_in ('0), .la_oenb ('0), .la_data_out (la_out8),
    .io_in ('0), .io_out (io_out8), .io_oeb (io_oeb8), .irq (irq8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One Wishbone transfer; gives up after 8 cycles without ack.
  task automatic wb_xfer(input bit to8, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output bit acked, output logic [31:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_w = d; sel = s;
    acked = 1'b0;
    rd = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (to8 ? ack8 : ack) begin
        acked = 1'b1;
        rd = to8 ? dat8 : dat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input bit to8, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string tag);
    bit acked;
    logic [31:0] rd;
    wb_xfer(to8, 1'b1, a, d, s, acked, rd);
    check_eq({tag, "_ack"}, 32'(acked), 32'd1);
  endtask

  task automatic wb_rd_chk(input bit to8, input logic [31:0] a, input logic [31:0] exp,
                           input string tag);
    bit acked;
    logic [31:0] rd;
    wb_xfer(to8, 1'b0, a, '0, 4'hF, acked, rd);
    check_eq({tag, "_ack"}, 32'(acked), 32'd1);
    check_eq(tag, rd, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acked;
    logic [31:0] rd;
    int n_ack;

    // Reset, then commit a LOAD value, then reset again with a write in flight.
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    wb_wr(0, Base + 32'h4, 32'h77, 4'hF, "pre_load");
    @(negedge clk);
    rst = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = Base + 32'h4; dat_w = 32'h55; sel = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_eq("rst_no_ack", 32'(ack), 32'd0);
    end
    check_eq("rst_oeb_io8", 32'(io_oeb[8]), 32'd0);
    check_eq("rst_oeb_io0", 32'(io_oeb[0]), 32'd1);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_io_out", io_out[31:0], 32'd0);
    check_eq("rst_dat", dat, 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    wb_rd_chk(0, Base + 32'h4, 32'h0, "rst_load0");
    wb_rd_chk(0, Base + 32'h0, 32'h0, "rst_ctrl0");
    wb_rd_chk(0, Base + 32'h8, 32'h0, "rst_count0");

    // Back-to-back requests: held cyc/stb for 4 edges gives 2 acks.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base; sel = 4'hF;
    n_ack = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (ack) n_ack++;
    end
    cyc = 1'b0; stb = 1'b0;
    check_eq("b2b_acks", 32'(n_ack), 32'd2);

    // ch0 up auto-reload, LOAD = 3.
    wb_wr(0, Base + 32'h4, 32'd3, 4'hF, "c0_load");
    wb_wr(0, Base + 32'h0, 32'h5, 4'hF, "c0_ctrl");
    check_eq("c0_cnt0", la_out[31:0], 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("c0_cnt%0d", k), la_out[31:0], 32'(k % 4));
      check_eq($sformatf("c0_io%0d", k), 32'(io_out[8]), (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    wb_wr(0, Base + 32'h0, 32'h0, 4'hF, "c0_stop");
    wb_rd_chk(0, Base + 32'hC, 32'h3, "c0_status");
    check_eq("c0_irq_masked", 32'(irq), 32'd0);
    wb_wr(0, Base + 32'hC, 32'h3, 4'hF, "c0_w1c");
    wb_rd_chk(0, Base + 32'hC, 32'h0, "c0_status_clr");

    // COUNT write coincident with a step: written value wins.
    wb_wr(0, Base + 32'h8, 32'h80, 4'hF, "c0_cnt80");
    wb_wr(0, Base + 32'h0, 32'h1, 4'hF, "c0_en");
    wb_wr(0, Base + 32'h8, 32'h100, 4'hF, "c0_cnt100");
    check_eq("c0_wr_wins", la_out[31:0], 32'h100);
    @(posedge clk);
    #1;
    check_eq("c0_after_wr", la_out[31:0], 32'h101);
    wb_wr(0, Base + 32'h0, 32'h0, 4'hF, "c0_stop2");
    wb_rd_chk(0, Base + 32'hC, 32'h0, "c0_no_tc");

    // ch1 down one-shot from 5 with IRQ_EN.
    wb_wr(0, Base + 32'h14, 32'd5, 4'hF, "c1_load");
    wb_wr(0, Base + 32'h18, 32'd5, 4'hF, "c1_count");
    wb_wr(0, Base + 32'h10, 32'hB, 4'hF, "c1_ctrl");
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) check_eq("c1_irq_k5", 32'(irq[0]), 32'd0);
      if (k == 6) begin
        check_eq("c1_io_k6", 32'(io_out[9]), 32'd1);
        check_eq("c1_irq_k6", 32'(irq[0]), 32'd0);
      end
      if (k == 7) begin
        check_eq("c1_io_k7", 32'(io_out[9]), 32'd0);
        check_eq("c1_irq_k7", 32'(irq[0]), 32'd1);
      end
    end
    wb_rd_chk(0, Base + 32'h18, 32'h0, "c1_count_hold");
    wb_rd_chk(0, Base + 32'h10, 32'hA, "c1_ctrl_en_clr");
    wb_rd_chk(0, Base + 32'h1C, 32'h1, "c1_status");
    wb_wr(0, Base + 32'h1C, 32'h1, 4'hF, "c1_w1c");
    @(posedge clk);
    #1;
    check_eq("c1_irq_clr", 32'(irq[0]), 32'd0);

    // ch2 up LOAD = 0 terminates every cycle; W1C always collides with a set.
    wb_wr(0, Base + 32'h20, 32'h5, 4'hF, "c2_ctrl");
    wb_wr(0, Base + 32'h2C, 32'h3, 4'hF, "c2_w1c_coll");
    wb_rd_chk(0, Base + 32'h2C, 32'h3, "c2_set_wins");
    wb_wr(0, Base + 32'h20, 32'h0, 4'hF, "c2_stop");
    wb_wr(0, Base + 32'h2C, 32'h3, 4'hF, "c2_w1c");
    wb_rd_chk(0, Base + 32'h2C, 32'h0, "c2_status_clr");

    // Bus edges.
    wb_rd_chk(0, Base + 32'h50, 32'h0, "unmapped_ch5");
    wb_xfer(0, 1'b0, Base + 32'h100, '0, 4'hF, acked, rd);
    check_eq("out_of_window_ack", 32'(acked), 32'd0);
    wb_wr(0, Base + 32'h34, 32'hFFFF_FFFF, 4'b0001, "c3_sel");
    wb_rd_chk(0, Base + 32'h34, 32'h0000_00FF, "c3_load_byte0");

    // 8-bit single-channel instance: wrap past LOAD without TC, then TC at 0x10.
    wb_wr(1, Base8 + 32'h4, 32'h10, 4'hF, "n8_load");
    wb_wr(1, Base8 + 32'h8, 32'hFE, 4'hF, "n8_count");
    wb_wr(1, Base8 + 32'h0, 32'h1, 4'hF, "n8_ctrl");
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("n8_cnt%0d", k), la_out8[31:0],
               (k <= 18) ? ((32'hFE + 32'(k)) & 32'hFF) : 32'h10);
      check_eq($sformatf("n8_io%0d", k), 32'(io_out8[8]), (k == 19) ? 32'd1 : 32'd0);
    end
    wb_rd_chk(1, Base8 + 32'hC, 32'h1, "n8_status");
    wb_rd_chk(1, Base8 + 32'h0, 32'h0, "n8_ctrl_en_clr");
    wb_rd_chk(1, Base8 + 32'h10, 32'h0, "n8_unmapped_ch1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
